aes256_encrypt_iter: RTL and testbench



---
 rtl/aes256_encrypt_iter.sv | 112 +++++++++++
 tb/tb_aes256_encrypt_iter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes256_encrypt_iter.sv
// Iterative AES-256 encryption core: one round per clock, 15 round keys supplied
// combinationally by the upstream key expansion and held stable while a block is in flight.
//   state | meaning
//   IDLE  | ready for plaintext; st holds the last ciphertext
//   RUN   | applying rounds 1..14, rnd selects the round key
//   DONE  | ciphertext presented until the downstream accepts it
module aes256_encrypt_iter (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [1919:0] round_keys_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [127:0]  plaintext_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [127:0]  ciphertext_o,
  output logic          busy_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  state_e        state_q;
  logic [3:0]    rnd_q;
  logic [127:0]  st_q;

  logic [7:0]    sb [16];
  logic [7:0]    sr [16];
  logic [7:0]    mc [16];
  logic [127:0]  rk [16];
  logic [127:0]  rk_sel;
  logic [127:0]  mix_w;
  logic [127:0]  last_w;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // rk[15] is never selected in RUN; it only fills out the power-of-two mux.
  for (genvar r = 0; r < 15; r++) begin : g_rk
    assign rk[r] = round_keys_i[r*128 +: 128];
  end
  assign rk[15] = '0;
  assign rk_sel = rk[rnd_q];

  // Byte k = row (k%4), column (k/4); ShiftRows takes row r from column (c+r)%4.
  for (genvar k = 0; k < 16; k++) begin : g_byte
    assign sb[k] = SBOX[st_q[127-8*k -: 8]];
    assign sr[k] = sb[(k % 4) + 4 * (((k / 4) + (k % 4)) % 4)];
    assign mix_w[127-8*k -: 8]  = mc[k] ^ rk_sel[127-8*k -: 8];
    assign last_w[127-8*k -: 8] = sr[k] ^ rk_sel[127-8*k -: 8];
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr[4*c];
    assign a1 = sr[4*c+1];
    assign a2 = sr[4*c+2];
    assign a3 = sr[4*c+3];
    assign mc[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
    assign mc[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
    assign mc[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
    assign mc[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      st_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            st_q    <= plaintext_i ^ rk[0];
            rnd_q   <= 4'd1;
            state_q <= RUN;
          end
        end
        RUN: begin
          rnd_q <= rnd_q + 4'd1;
          if (rnd_q == 4'd14) begin
            st_q    <= last_w;
            state_q <= DONE;
          end else begin
            st_q <= mix_w;
          end
        end
        DONE: begin
          if (out_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o   = (state_q == IDLE);
  assign out_valid_o  = (state_q == DONE);
  assign busy_o       = (state_q != IDLE);
  assign ciphertext_o = st_q;

endmodule

// File: tb/tb_aes256_encrypt_iter.sv
// Self-checking bench for aes256_encrypt_iter: bench-side key expansion feeds the round
// keys, expected ciphertexts are known-answer constants queued at acceptance.
module tb_aes256_encrypt_iter;

  localparam logic [255:0] KEY_C3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_C3   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CT_ZERO = 128'hdc95c078a2408989ad48a21492842087;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [1919:0] round_keys_i = '0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [127:0]  plaintext_i = '0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [127:0]  ciphertext_o;
  logic          busy_o;

  int n_chk  = 0;
  int n_pass = 0;
  logic [127:0] exp_q [$];

  aes256_encrypt_iter dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .round_keys_i (round_keys_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .plaintext_i  (plaintext_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .ciphertext_o (ciphertext_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]};
  endfunction

  function automatic logic [1919:0] expand(input logic [255:0] key);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] rk;
    rc = 8'h01;
    rk = '0;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = rc << 1;
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) rk[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rk;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Offers one block and pushes its expected ciphertext at the accepting edge.
  task automatic accept_block(input logic [255:0] key, input logic [127:0] pt,
                              input logic [127:0] ct, output bit ok);
    ok = 1'b0;
    round_keys_i = expand(key);
    plaintext_i  = pt;
    in_valid_i   = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (in_ready_o) begin
        exp_q.push_back(ct);
        ok = 1'b1;
      end
      step();
    end
    in_valid_i = 1'b0;
  endtask

  // Returns the number of edges from the accepting edge (counted as 1) until out_valid_o.
  task automatic wait_valid(output int edges);
    edges = 1;
    while (!out_valid_o && edges < 60) begin
      step();
      edges++;
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    #3;
    n_chk++; if (in_ready_o !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready_o); else n_pass++;
    n_chk++; if (out_valid_o !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid_o); else n_pass++;
    n_chk++; if (ciphertext_o !== 128'h0) $display("FAIL reset_ct got=%h exp=0", ciphertext_o); else n_pass++;
    n_chk++; if (busy_o !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy_o); else n_pass++;
    step();
    step();
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_fips_c3();
    bit ok;
    int edges;
    logic [127:0] e;
    out_ready_i = 1'b0;
    accept_block(KEY_C3, PT_C3, CT_C3, ok);
    n_chk++; if (!ok) $display("FAIL c3_accept got=no_accept exp=accept"); else n_pass++;
    n_chk++; if (busy_o !== 1'b1) $display("FAIL c3_busy got=%b exp=1", busy_o); else n_pass++;
    wait_valid(edges);
    n_chk++; if (edges != 15) $display("FAIL c3_latency got=%0d exp=15", edges); else n_pass++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
    n_chk++; if (ciphertext_o !== e) $display("FAIL c3_ct got=%h exp=%h", ciphertext_o, e); else n_pass++;
    out_ready_i = 1'b1;
    step();
    n_chk++; if (in_ready_o !== 1'b1) $display("FAIL c3_back_idle got=%b exp=1", in_ready_o); else n_pass++;
    out_ready_i = 1'b0;
  endtask

  task automatic test_zero_key();
    bit ok;
    int edges;
    logic [127:0] e;
    out_ready_i = 1'b1;
    accept_block(256'h0, 128'h0, CT_ZERO, ok);
    wait_valid(edges);
    n_chk++; if (edges != 15) $display("FAIL zero_latency got=%0d exp=15", edges); else n_pass++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
    n_chk++; if (ciphertext_o !== e) $display("FAIL zero_ct got=%h exp=%h", ciphertext_o, e); else n_pass++;
    step();
    out_ready_i = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    int edges;
    logic [127:0] e;
    logic [127:0] hold;
    out_ready_i = 1'b0;
    accept_block(KEY_C3, PT_C3, CT_C3, ok);
    wait_valid(edges);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
    n_chk++; if (ciphertext_o !== e) $display("FAIL bp_ct got=%h exp=%h", ciphertext_o, e); else n_pass++;
    hold = e;
    plaintext_i = 128'h0;
    for (int i = 0; i < 20; i++) begin
      in_valid_i = i[0];
      step();
      n_chk++; if (out_valid_o !== 1'b1) $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, out_valid_o); else n_pass++;
      n_chk++; if (ciphertext_o !== hold) $display("FAIL bp_stable cyc=%0d got=%h exp=%h", i, ciphertext_o, hold); else n_pass++;
      n_chk++; if (in_ready_o !== 1'b0) $display("FAIL bp_ready cyc=%0d got=%b exp=0", i, in_ready_o); else n_pass++;
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    step();
    n_chk++; if (in_ready_o !== 1'b1) $display("FAIL bp_release_ready got=%b exp=1", in_ready_o); else n_pass++;
    n_chk++; if (out_valid_o !== 1'b0) $display("FAIL bp_release_valid got=%b exp=0", out_valid_o); else n_pass++;
    out_ready_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc, last_acc, acc_cnt, done_cnt;
    logic [127:0] e;
    cyc = 0; last_acc = -1; acc_cnt = 0; done_cnt = 0;
    out_ready_i = 1'b1;
    in_valid_i = 1'b1;
    round_keys_i = expand(KEY_C3);
    plaintext_i = PT_C3;
    while (done_cnt < 4 && cyc < 200) begin
      if (in_ready_o && in_valid_i && acc_cnt < 4) begin
        exp_q.push_back(acc_cnt[0] ? CT_ZERO : CT_C3);
        if (last_acc >= 0) begin
          n_chk++; if (cyc - last_acc != 16) $display("FAIL b2b_spacing got=%0d exp=16", cyc - last_acc); else n_pass++;
        end
        last_acc = cyc;
        acc_cnt++;
      end
      if (out_valid_o && out_ready_i) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        n_chk++; if (ciphertext_o !== e) $display("FAIL b2b_ct blk=%0d got=%h exp=%h", done_cnt, ciphertext_o, e); else n_pass++;
        done_cnt++;
        round_keys_i = acc_cnt[0] ? expand(256'h0) : expand(KEY_C3);
        plaintext_i  = acc_cnt[0] ? 128'h0 : PT_C3;
      end
      step();
      if (acc_cnt >= 4) in_valid_i = 1'b0;
      cyc++;
    end
    n_chk++; if (done_cnt != 4) $display("FAIL b2b_done got=%0d exp=4", done_cnt); else n_pass++;
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int edges;
    logic [127:0] e;
    out_ready_i = 1'b1;
    accept_block(KEY_C3, PT_C3, CT_C3, ok);
    for (int i = 0; i < 6; i++) step();
    rst_ni = 1'b0;
    #1;
    n_chk++; if (in_ready_o !== 1'b1) $display("FAIL mid_rst_ready got=%b exp=1", in_ready_o); else n_pass++;
    n_chk++; if (busy_o !== 1'b0) $display("FAIL mid_rst_busy got=%b exp=0", busy_o); else n_pass++;
    n_chk++; if (ciphertext_o !== 128'h0) $display("FAIL mid_rst_ct got=%h exp=0", ciphertext_o); else n_pass++;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++; if (out_valid_o !== 1'b0) $display("FAIL mid_rst_valid cyc=%0d got=%b exp=0", i, out_valid_o); else n_pass++;
    end
    rst_ni = 1'b1;
    step();
    accept_block(KEY_C3, PT_C3, CT_C3, ok);
    wait_valid(edges);
    n_chk++; if (edges != 15) $display("FAIL mid_rst_latency got=%0d exp=15", edges); else n_pass++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
    n_chk++; if (ciphertext_o !== e) $display("FAIL mid_rst_ct_after got=%h exp=%h", ciphertext_o, e); else n_pass++;
    step();
    out_ready_i = 1'b0;
  endtask

  // Random handshakes against an independent IDLE/RUN/DONE model.
  task automatic test_random();
    int ms, mcnt;
    logic [127:0] e;
    rst_ni = 1'b0;
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    exp_q.delete();
    step();
    rst_ni = 1'b1;
    step();
    ms = 0; mcnt = 0;
    for (int i = 0; i < 500; i++) begin
      if (ms == 0) begin
        if ($urandom_range(0, 1) == 1) begin
          round_keys_i = expand(KEY_C3);
          plaintext_i  = PT_C3;
        end else begin
          round_keys_i = expand(256'h0);
          plaintext_i  = 128'h0;
        end
      end
      in_valid_i  = ($urandom_range(0, 3) == 0);
      out_ready_i = ($urandom_range(0, 2) == 0);
      n_chk++; if (busy_o !== !in_ready_o) $display("FAIL rnd_busy cyc=%0d busy=%b ready=%b", i, busy_o, in_ready_o); else n_pass++;
      n_chk++; if (out_valid_o !== (ms == 2)) $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, out_valid_o, ms == 2); else n_pass++;
      n_chk++; if (in_ready_o !== (ms == 0)) $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, in_ready_o, ms == 0); else n_pass++;
      case (ms)
        0: if (in_valid_i) begin
             exp_q.push_back((plaintext_i == PT_C3) ? CT_C3 : CT_ZERO);
             ms = 1; mcnt = 1;
           end
        1: if (mcnt == 14) ms = 2; else mcnt++;
        default: if (out_ready_i) begin
             e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
             n_chk++; if (ciphertext_o !== e) $display("FAIL rnd_ct cyc=%0d got=%h exp=%h", i, ciphertext_o, e); else n_pass++;
             ms = 0;
           end
      endcase
      step();
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fips_c3();
    test_zero_key();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
